// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Purpose:
//   Shares one external combinational 32-bit ALU between NUM_REQ requesters.
//   A round-robin arbiter picks one valid request in IDLE and registers its
//   operands onto the ALU bus for the EXEC cycle. The ALU result and zero flag
//   are captured at the end of EXEC. The captured response is then held in
//   RESP until the granted requester accepts it.
//   Timing: accept in cycle 0, ALU busy in cycle 1, response visible from
//   cycle 2.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready only in IDLE)
//   req_a/req_b       packed 32-bit operands, requester i at [32i+31:32i]
//   req_op            packed 3-bit opcodes, requester i at [3i+2:3i]
//   resp_valid/ready  per-requester response handshake (one-hot valid)
//   resp_result       captured ALU result (shared bus)
//   resp_zero         captured ALU zero flag
//   resp_err          illegal-opcode flag (only with ALU_ARB_OPCHECK_EN)
//   grant_idx         current or last granted requester
//   alu_a/alu_b/alu_op registered operands driven to the external ALU
//   alu_result/zero   outputs returned by the external ALU
//
// Configuration macro:
//   ALU_ARB_OPCHECK_EN
//     Defined:   illegal opcodes are accepted, but the ALU sees 3'b000.
//                The response is forced to result 0, zero 1, err 1.
//     Undefined: opcodes pass through unchecked, and resp_err stays 0.
// -----------------------------------------------------------------------------
module alu_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [32*NUM_REQ-1:0]   req_a,
   input  logic [32*NUM_REQ-1:0]   req_b,
   input  logic [3*NUM_REQ-1:0]    req_op,
   output logic [NUM_REQ-1:0]      resp_valid,
   input  logic [NUM_REQ-1:0]      resp_ready,
   output logic [31:0]             resp_result,
   output logic                    resp_zero,
   output logic                    resp_err,
   output logic [IDX_W-1:0]        grant_idx,
   output logic [31:0]             alu_a,
   output logic [31:0]             alu_b,
   output logic [2:0]              alu_op,
   input  logic [31:0]             alu_result,
   input  logic                    alu_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

   // Legal opcodes: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
   function automatic logic op_illegal(input logic [2:0] op);
      logic bad;
      case (op)
         3'b000, 3'b001, 3'b010, 3'b110, 3'b111: bad = 1'b0;
         default:                                bad = 1'b1;
      endcase
      return bad;
   endfunction

   state_t                  state_r, state_nxt_s;
   logic [IDX_W-1:0]        rr_ptr_r;
   logic [IDX_W-1:0]        grant_idx_r;
   logic [31:0]             alu_a_r, alu_b_r;
   logic [2:0]              alu_op_r;
   logic                    op_err_r;
   logic [31:0]             resp_result_r;
   logic                    resp_zero_r;
   logic                    resp_err_r;

   logic [(1<<IDX_W)-1:0]   valid_ext_s;
   logic [IDX_W:0]          cand_s;
   logic [IDX_W:0]          rr_nxt_s;
   logic                    found_s;
   logic [IDX_W-1:0]        grant_s;
   logic [31:0]             sel_a_s, sel_b_s;
   logic [2:0]              sel_op_s;
   logic                    resp_ack_s;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      valid_ext_s                = '0;
      valid_ext_s[NUM_REQ-1:0]   = req_valid;
      found_s                    = 1'b0;
      grant_s                    = '0;
      cand_s                     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
         if (cand_s >= NUM_REQ_W) begin
            cand_s = cand_s - NUM_REQ_W;
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && valid_ext_s[cand_s[IDX_W-1:0]]) begin
            found_s = 1'b1;
            grant_s = cand_s[IDX_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Payload mux for the candidate grant and the pointer that follows it.
   always_comb begin
      sel_a_s  = 32'h0000_0000;
      sel_b_s  = 32'h0000_0000;
      sel_op_s = 3'b000;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s == IDX_W'(i)) begin
            sel_a_s  = req_a[32*i +: 32];
            sel_b_s  = req_b[32*i +: 32];
            sel_op_s = req_op[3*i +: 3];
         end else begin
            sel_a_s  = sel_a_s;
         end
      end
      rr_nxt_s = {1'b0, grant_s} + {{IDX_W{1'b0}}, 1'b1};
      if (rr_nxt_s >= NUM_REQ_W) begin
         rr_nxt_s = '0;
      end else begin
         rr_nxt_s = rr_nxt_s;
      end
   end

   // Handshake decode: ready only in IDLE for the grant, valid only in RESP.
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      resp_ack_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (state_r == ST_IDLE && found_s && grant_s == IDX_W'(i)) begin
            req_ready[i] = 1'b1;
         end else begin
            req_ready[i] = 1'b0;
         end
         if (state_r == ST_RESP && grant_idx_r == IDX_W'(i)) begin
            resp_valid[i] = 1'b1;
            resp_ack_s    = resp_ready[i];
         end else begin
            resp_valid[i] = 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EXEC: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (resp_ack_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath: load operands on accept, capture the ALU response after EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r      <= '0;
         grant_idx_r   <= '0;
         alu_a_r       <= 32'h0000_0000;
         alu_b_r       <= 32'h0000_0000;
         alu_op_r      <= 3'b000;
         op_err_r      <= 1'b0;
         resp_result_r <= 32'h0000_0000;
         resp_zero_r   <= 1'b0;
         resp_err_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  grant_idx_r <= grant_s;
                  rr_ptr_r    <= rr_nxt_s[IDX_W-1:0];
                  alu_a_r     <= sel_a_s;
                  alu_b_r     <= sel_b_s;
`ifdef ALU_ARB_OPCHECK_EN
                  alu_op_r    <= op_illegal(sel_op_s) ? 3'b000 : sel_op_s;
                  op_err_r    <= op_illegal(sel_op_s);
`else
                  alu_op_r    <= sel_op_s;
                  op_err_r    <= 1'b0;
`endif
               end else begin
                  grant_idx_r <= grant_idx_r;
               end
            end
            ST_EXEC: begin
               if (op_err_r) begin
                  resp_result_r <= 32'h0000_0000;
                  resp_zero_r   <= 1'b1;
                  resp_err_r    <= 1'b1;
               end else begin
                  resp_result_r <= alu_result;
                  resp_zero_r   <= alu_zero;
                  resp_err_r    <= 1'b0;
               end
            end
            default: begin
               resp_result_r <= resp_result_r;
            end
         endcase
      end
   end

   assign grant_idx   = grant_idx_r;
   assign alu_a       = alu_a_r;
   assign alu_b       = alu_b_r;
   assign alu_op      = alu_op_r;
   assign resp_result = resp_result_r;
   assign resp_zero   = resp_zero_r;
   assign resp_err    = resp_err_r;

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 32-bit ALU instance (ops: AND/OR/ADD/SUB/SLT, zero flag) between NUM_REQ requesters, e.g. a main datapath and a branch/address unit.
- Round-robin arbitration with a valid/ready request channel and a valid/ready response channel per requester.
- Registers each granted operation, drives it onto the ALU, captures the result, and returns it only to the granted requester.
- Sits between the requesters and the ALU; the ALU itself is unchanged and instantiated outside this block.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- IDX_W, 2, width of the grant index; must satisfy 2**IDX_W >= NUM_REQ.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accept.
- req_a  input  32*NUM_REQ  operand A; requester i is bits [32i+31:32i].
- req_b  input  32*NUM_REQ  operand B; same packing as req_a.
- req_op  input  3*NUM_REQ  ALU opcode; requester i is bits [3i+2:3i].
- resp_valid  output  NUM_REQ  response valid; at most one bit high.
- resp_ready  input  NUM_REQ  per-requester response accept.
- resp_result  output  32  result, shared bus, meaningful only while resp_valid != 0.
- resp_zero  output  1  captured ALU zero flag.
- resp_err  output  1  illegal-opcode flag; see Optional Feature.
- grant_idx  output  IDX_W  index of the current or last granted requester.
- alu_a  output  32  to ALU operand A.
- alu_b  output  32  to ALU operand B.
- alu_op  output  3  to ALU opcode.
- alu_result  input  32  from ALU result.
- alu_zero  input  1  from ALU zero flag.

Behaviour:
- Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (unsigned compare). 011, 100 and 101 are illegal.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, the grant g is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only; every other req_ready bit is 0.
  - On the clock edge: capture req_a/req_b/req_op of g into operand registers, set grant_idx=g, set rr_ptr=(g+1) mod NUM_REQ, go to EXEC.
  - With no req_valid set, stay in IDLE; all req_ready bits are 0.
- EXEC:
  - alu_a, alu_b and alu_op are driven from the operand registers. They are registered outputs and stable for the whole state.
  - On the clock edge: capture alu_result and alu_zero into the response registers, go to RESP.
- RESP:
  - resp_valid[grant_idx]=1.
  - resp_result, resp_zero and resp_err are held stable until resp_ready[grant_idx]=1.
  - The response transfers on the edge where resp_ready[grant_idx]=1; the FSM then returns to IDLE.
  - resp_ready bits of non-granted requesters are ignored.
- Latency and throughput:
  - The accept cycle is cycle 0; the response is first visible in cycle 2.
  - Peak throughput is one operation per 3 cycles with zero response backpressure.
- No request is accepted outside IDLE; req_ready is 0 in EXEC and RESP.
- Requesters must hold req_valid and their payload stable until accepted.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- A requester waits at most NUM_REQ-1 other transactions before being granted.
- Simultaneous events:
  - A new req_valid that rises during EXEC or RESP is considered only at the next IDLE cycle.
  - Deasserting req_valid before grant withdraws the request with no side effect.
- Reset values, applied asynchronously on rst_n=0:
  - State IDLE; rr_ptr=0; grant_idx=0.
  - alu_a=0, alu_b=0, alu_op=3'b000.
  - resp_result=0, resp_zero=0, resp_err=0.
  - req_ready=0, resp_valid=0.
- Reset mid-transaction aborts the transaction; no response is ever delivered for it.
- Release from reset is synchronous to clk. The first grant is possible in the first cycle after rst_n rises.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - An illegal opcode is still accepted, but in EXEC alu_op is driven to 3'b000.
  - The captured response is forced to resp_result=0, resp_zero=1, resp_err=1.
  - Handshake timing is unchanged.
- Undefined:
  - Opcodes pass through to the ALU unchecked; the captured ALU outputs are returned as-is.
  - resp_err is tied to 0.

Test Plan:
- Reset with rst_n=0 mid-EXEC, from a req0 ADD 5+7 -> all outputs reach their reset values immediately; no resp_valid ever appears for that request.
- req0 only, ADD A=0x1 B=0x2, resp_ready=1 -> req_ready[0] high in cycle 0; resp_valid[0] high in cycle 2 with result 0x3, zero=0; FSM back in IDLE in cycle 3.
- req0 and req1 both held valid, SUB 0x20-0x20 and SLT 0x1<0x2 -> req0 is served first with result 0, zero=1; req1 is served next with result 0x1; repeated requests then alternate 0,1,0,1.
- req1 OR 0xF0|0x0F with resp_ready[1]=0 for 5 cycles -> resp_valid[1] and result 0xFF are held stable throughout; no new grant occurs; completes on the cycle resp_ready[1] rises.
- req0 SLT A=0xFFFFFFFF B=0x1 -> result 0, zero=1 (unsigned compare).
- Opcode 3'b100 on req0 -> with ALU_ARB_OPCHECK_EN: alu_op=000, result 0, err=1; without it: alu_op=100 on the ALU bus and err=0.
